cpu_ibus_responder: RTL and testbench
=====================================

// Module: cpu_ibus_responder
// PURPOSE
//  Responder end of the CPU instruction-fetch bus (request/ready/address/rdata) driven by the ICache.
//  Serves 32-bit word reads from a synchronous single-port SRAM with programmable wait states.
//  Flags out-of-range fetches.
//  Sits between the fetch-side ICache bus and the instruction SRAM/boot ROM.
// PARAMETERS
//  BASE_ADDRESS  32'h0000_0000  byte address of word 0; must be 4-byte aligned
//  SIZE_WORDS    4096           SRAM depth in words; power of two; ADDR_BITS = $clog2(SIZE_WORDS)
//  WAIT_STATES   0              extra cycles inserted after SRAM data arrives; 0..15
// PORTS
//  i_clock          in   1          clock; all logic on rising edge
//  i_reset_n        in   1          asynchronous, active-low reset
//  i_bus_request    in   1          initiator holds high, address stable, until ready seen
//  i_bus_address    in   32         byte address; bits [1:0] ignored
//  o_bus_ready      out  1          one-cycle pulse; o_bus_rdata valid in the same cycle
//  o_bus_rdata      out  32         read word; holds its value until the next ready
//  o_bus_fault      out  1          one-cycle pulse, coincident with ready, for an out-of-range address
//  o_mem_read       out  1          SRAM read strobe, one cycle
//  o_mem_address    out  ADDR_BITS  SRAM word address
//  i_mem_rdata      in   32         SRAM data, valid the cycle after o_mem_read
// BEHAVIOUR
//  Reset (async assert, sync release) drives:
//   - state IDLE; o_bus_ready=0; o_bus_fault=0; o_mem_read=0; o_mem_address=0;
//     o_bus_rdata=0; wait counter=0.
//   - Reset mid-transaction aborts the transaction; no ready is issued.
//  In range: BASE_ADDRESS <= addr < BASE_ADDRESS+4*SIZE_WORDS.
//   - Compare in 33-bit arithmetic; no wrap past 2^32.
//   - Word index = (addr-BASE_ADDRESS)>>2.
//  FSM (edge T = first edge at which IDLE samples i_bus_request=1):
//   IDLE:
//    - request and in range -> READ: o_mem_read=1 and o_mem_address=index during cycle T+1.
//    - request and out of range -> RESPOND at once: o_bus_rdata=0 and o_bus_fault=1.
//   READ:
//    - o_mem_read deasserts after 1 cycle.
//    - Wait 1+WAIT_STATES cycles, then latch i_mem_rdata into o_bus_rdata -> RESPOND.
//   RESPOND:
//    - o_bus_ready=1 for exactly one cycle -> RELEASE.
//   RELEASE:
//    - Hold until i_bus_request is sampled 0, then -> IDLE.
//    - No second ready is ever issued while request stays high.
//  Latency, request rise to ready: in range 2+WAIT_STATES cycles; out of range 1 cycle.
//  Request dropped in READ (jump/flush):
//   - The SRAM read completes internally but no ready is issued.
//   - At data-latch time the FSM -> IDLE; o_bus_rdata is not updated.
//  Back-to-back: minimum gap between readies is 2+WAIT_STATES cycles plus 1 RELEASE cycle.
//  The address is registered at edge T; later address changes during the transaction are ignored.
// CONFIGURATION
//  IBUS_PREFETCH_EN defined:
//   - After each in-range ready for address A, with A+4 in range and the port idle, one
//     speculative SRAM read of A+4 is issued into a one-entry buffer {valid, addr, data}.
//   - IDLE request matching the buffer address with valid=1 -> RESPOND next cycle (latency 1),
//     with no SRAM access.
//   - Mismatch -> buffer invalidated and a normal READ is issued. If the prefetch is still
//     in flight, the READ is issued after the prefetch data returns.
//   - Reset invalidates the buffer.
//  IBUS_PREFETCH_EN undefined:
//   - No buffer logic; every in-range request goes through READ.
// TESTING
//  1. WAIT_STATES=0, request addr 0x0000_0010, SRAM[4]=0x0000_0013 -> ready 2 cycles after request; rdata=0x0000_0013; fault=0.
//  2. WAIT_STATES=3, request 0x0000_0008 -> o_mem_read one cycle with mem_address=2; ready 5 cycles after request; exactly one ready while request held 10 cycles.
//  3. SIZE_WORDS=4096, request 0x0000_4000 (past end) -> ready+fault 1 cycle after request; rdata=0; o_mem_read stays 0.
//  4. Request 0x20, drop request one cycle later -> no ready; next request 0x24 completes normally with SRAM[9].
//  5. Assert i_reset_n=0 during READ -> outputs 0 immediately (before next edge); after release, a request to 0x0 completes normally.
//  6. IBUS_PREFETCH_EN: read 0x100 then 0x104 -> second ready 1 cycle after request; then 0x200 -> buffer miss, normal latency, correct data.

Source files
------------

// File: rtl/cpu_ibus_responder.sv
// cpu_ibus_responder: responder side of the CPU instruction-fetch bus.
// Serves aligned 32-bit word reads from a synchronous single-port SRAM that
// returns data one cycle after its read strobe. WAIT_STATES adds extra cycles
// before the data is handed back. Fetches outside
// [BASE_ADDRESS, BASE_ADDRESS + 4*SIZE_WORDS) get a fault response with zero data.
// Optional feature: define IBUS_PREFETCH_EN to add a one-entry next-word
// prefetch buffer. Without the macro, every in-range fetch reads the SRAM.
module cpu_ibus_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int unsigned SIZE_WORDS   = 4096,
  parameter int unsigned WAIT_STATES  = 0,
  localparam int unsigned ADDR_BITS   = $clog2(SIZE_WORDS)
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_bus_request,
  input  logic [31:0]          i_bus_address,
  output logic                 o_bus_ready,
  output logic [31:0]          o_bus_rdata,
  output logic                 o_bus_fault,
  output logic                 o_mem_read,
  output logic [ADDR_BITS-1:0] o_mem_address,
  input  logic [31:0]          i_mem_rdata
);

  // The range check uses 33 bits, so the upper limit cannot wrap past 2^32.
  localparam logic [32:0] BASE_EXT  = {1'b0, BASE_ADDRESS};
  localparam logic [32:0] LIMIT_EXT = BASE_EXT + (33'(SIZE_WORDS) << 2);
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES);

  // RESPOND is the cycle in which the response is formed. The registered
  // ready/fault pulse appears on the edge that leaves RESPOND, while the FSM
  // is already in RELEASE.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_RESPOND,
    ST_RELEASE
  } state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             wait_cnt_reg, wait_cnt_next;
  logic                   aborted_reg, aborted_next;
  logic                   fault_pend_reg, fault_pend_next;
  logic                   mem_read_reg, mem_read_next;
  logic [ADDR_BITS-1:0]   mem_address_reg, mem_address_next;
  logic                   bus_ready_reg, bus_ready_next;
  logic                   bus_fault_reg, bus_fault_next;
  logic [31:0]            bus_rdata_reg, bus_rdata_next;

  logic                   req_in_range;
  logic [ADDR_BITS-1:0]   req_index;
  logic                   port_free;

`ifdef IBUS_PREFETCH_EN
  localparam logic [ADDR_BITS-1:0] INDEX_LAST = ADDR_BITS'(SIZE_WORDS - 1);
  localparam logic [ADDR_BITS-1:0] INDEX_ONE  = ADDR_BITS'(1);

  logic                   hit_pend_reg, hit_pend_next;
  logic [ADDR_BITS-1:0]   addr_index_reg, addr_index_next;
  logic                   pf_valid_reg, pf_valid_next;
  logic [ADDR_BITS-1:0]   pf_index_reg, pf_index_next;
  logic [31:0]            pf_data_reg, pf_data_next;
  // 0: no prefetch in flight, 1: strobe issued, 2: SRAM data valid this cycle
  logic [1:0]             pf_stage_reg, pf_stage_next;

  // A new request waits while a speculative read still occupies the SRAM port.
  assign port_free = (pf_stage_reg == 2'd0);
`else
  assign port_free = 1'b1;
`endif

  assign req_in_range = ({1'b0, i_bus_address} >= BASE_EXT) &&
                        ({1'b0, i_bus_address} < LIMIT_EXT);
  assign req_index    = ADDR_BITS'((i_bus_address - BASE_ADDRESS) >> 2);

  assign o_bus_ready   = bus_ready_reg;
  assign o_bus_rdata   = bus_rdata_reg;
  assign o_bus_fault   = bus_fault_reg;
  assign o_mem_read    = mem_read_reg;
  assign o_mem_address = mem_address_reg;

  // State and output registers; reset aborts any transaction in progress.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg       <= ST_IDLE;
      wait_cnt_reg    <= '0;
      aborted_reg     <= 1'b0;
      fault_pend_reg  <= 1'b0;
      mem_read_reg    <= 1'b0;
      mem_address_reg <= '0;
      bus_ready_reg   <= 1'b0;
      bus_fault_reg   <= 1'b0;
      bus_rdata_reg   <= '0;
`ifdef IBUS_PREFETCH_EN
      hit_pend_reg    <= 1'b0;
      addr_index_reg  <= '0;
      pf_valid_reg    <= 1'b0;
      pf_index_reg    <= '0;
      pf_data_reg     <= '0;
      pf_stage_reg    <= 2'd0;
`endif
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      aborted_reg     <= aborted_next;
      fault_pend_reg  <= fault_pend_next;
      mem_read_reg    <= mem_read_next;
      mem_address_reg <= mem_address_next;
      bus_ready_reg   <= bus_ready_next;
      bus_fault_reg   <= bus_fault_next;
      bus_rdata_reg   <= bus_rdata_next;
`ifdef IBUS_PREFETCH_EN
      hit_pend_reg    <= hit_pend_next;
      addr_index_reg  <= addr_index_next;
      pf_valid_reg    <= pf_valid_next;
      pf_index_reg    <= pf_index_next;
      pf_data_reg     <= pf_data_next;
      pf_stage_reg    <= pf_stage_next;
`endif
    end
  end

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    aborted_next     = aborted_reg;
    fault_pend_next  = fault_pend_reg;
    mem_read_next    = 1'b0;
    mem_address_next = mem_address_reg;
    bus_ready_next   = 1'b0;
    bus_fault_next   = 1'b0;
    bus_rdata_next   = bus_rdata_reg;
`ifdef IBUS_PREFETCH_EN
    hit_pend_next    = hit_pend_reg;
    addr_index_next  = addr_index_reg;
    pf_valid_next    = pf_valid_reg;
    pf_index_next    = pf_index_reg;
    pf_data_next     = pf_data_reg;
    pf_stage_next    = pf_stage_reg;
    // Capture the speculative word once the SRAM has returned it.
    case (pf_stage_reg)
      2'd1: pf_stage_next = 2'd2;
      2'd2: begin
        pf_stage_next = 2'd0;
        pf_data_next  = i_mem_rdata;
        pf_valid_next = 1'b1;
      end
      default: ;
    endcase
`endif

    case (state_reg)
      ST_IDLE: begin
        if (i_bus_request && port_free) begin
          aborted_next    = 1'b0;
          fault_pend_next = !req_in_range;
          wait_cnt_next   = '0;
`ifdef IBUS_PREFETCH_EN
          hit_pend_next   = 1'b0;
          addr_index_next = req_index;
`endif
          if (!req_in_range) begin
            state_next = ST_RESPOND;
          end
`ifdef IBUS_PREFETCH_EN
          else if (pf_valid_reg && (pf_index_reg == req_index)) begin
            hit_pend_next = 1'b1;
            state_next    = ST_RESPOND;
          end
`endif
          else begin
`ifdef IBUS_PREFETCH_EN
            pf_valid_next    = 1'b0;
`endif
            mem_read_next    = 1'b1;
            mem_address_next = req_index;
            state_next       = ST_READ;
          end
        end
      end

      ST_READ: begin
        // A dropped request (jump/flush) lets the read finish silently.
        if (!i_bus_request) begin
          aborted_next = 1'b1;
        end
        if (wait_cnt_reg == WAIT_LAST) begin
          wait_cnt_next = '0;
          state_next    = ST_RESPOND;
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end

      ST_RESPOND: begin
        if (aborted_reg || !i_bus_request) begin
          state_next = ST_IDLE;
        end else begin
          bus_ready_next = 1'b1;
          bus_fault_next = fault_pend_reg;
          state_next     = ST_RELEASE;
          if (fault_pend_reg) begin
            bus_rdata_next = '0;
          end
`ifdef IBUS_PREFETCH_EN
          else if (hit_pend_reg) begin
            bus_rdata_next = pf_data_reg;
          end
`endif
          else begin
            bus_rdata_next = i_mem_rdata;
          end
`ifdef IBUS_PREFETCH_EN
          // The SRAM port is idle now, so fetch the next word speculatively.
          if (!fault_pend_reg && (addr_index_reg != INDEX_LAST)) begin
            mem_read_next    = 1'b1;
            mem_address_next = addr_index_reg + INDEX_ONE;
            pf_index_next    = addr_index_reg + INDEX_ONE;
            pf_valid_next    = 1'b0;
            pf_stage_next    = 2'd1;
          end
`endif
        end
      end

      ST_RELEASE: begin
        if (!i_bus_request) begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_ibus_responder.sv
// Testbench for cpu_ibus_responder. It runs table vectors for the defined
// corner cases, hand sequences for abort, reset and prefetch, and randomized
// fetches checked against a reference model in the bench.
module tb_cpu_ibus_responder;
  localparam int          WS   = 3;
  localparam int          SW   = 4096;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        i_clock = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_bus_request = 1'b0;
  logic [31:0] i_bus_address = '0;
  logic        o_bus_ready;
  logic [31:0] o_bus_rdata;
  logic        o_bus_fault;
  logic        o_mem_read;
  logic [11:0] o_mem_address;
  logic [31:0] i_mem_rdata;

  cpu_ibus_responder #(
    .BASE_ADDRESS (BASE),
    .SIZE_WORDS   (SW),
    .WAIT_STATES  (WS)
  ) dut (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_bus_request (i_bus_request),
    .i_bus_address (i_bus_address),
    .o_bus_ready   (o_bus_ready),
    .o_bus_rdata   (o_bus_rdata),
    .o_bus_fault   (o_bus_fault),
    .o_mem_read    (o_mem_read),
    .o_mem_address (o_mem_address),
    .i_mem_rdata   (i_mem_rdata)
  );

  always #5 i_clock = ~i_clock;

  // Synchronous SRAM: output register loaded on a read strobe, then held.
  logic [31:0] mem [SW];
  logic [31:0] sram_q = '0;
  always @(posedge i_clock) if (o_mem_read) sram_q <= mem[o_mem_address];
  assign i_mem_rdata = sram_q;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Reference model: range rule, word index, and one-entry next-word buffer.
  bit pf_v = 1'b0;
  int pf_w = 0;

  function automatic bit model_in_range(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * SW);
  endfunction

  function automatic int model_word(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic model_note(input logic [31:0] a);
    if (model_in_range(a)) begin
      pf_v = (model_word(a) + 1 < SW);
      pf_w = model_word(a) + 1;
    end
  endtask

  // One bus transaction: raise request, wait for ready (bounded), optionally
  // hold request, drop it, then idle 3 cycles while watching for stray readies.
  task automatic run_txn(input logic [31:0] a, input int hold, input bit scramble,
                         output int lat, output logic [31:0] data, output logic flt,
                         output int nmr, output logic [11:0] maddr, output int extra);
    lat = -1; data = '0; flt = 1'b0; nmr = 0; maddr = '0; extra = 0;
    i_bus_address = a;
    i_bus_request = 1'b1;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(posedge i_clock); @(negedge i_clock);
      if (scramble) i_bus_address = $urandom;
      if (o_bus_ready) begin
        lat = c - 1; data = o_bus_rdata; flt = o_bus_fault;
      end else if (o_mem_read) begin
        nmr++; maddr = o_mem_address;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge i_clock); @(negedge i_clock);
      if (o_bus_ready) extra++;
    end
    i_bus_request = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(posedge i_clock); @(negedge i_clock);
      if (o_bus_ready) extra++;
    end
    $display("txn addr=%08h lat=%0d data=%08h fault=%0b memrd=%0d extra=%0d",
             a, lat, data, flt, nmr, extra);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          hold;
    int          exp_lat;
    logic [31:0] exp_data;
    logic        exp_fault;
    int          exp_nmr;
    logic [11:0] exp_maddr;
  } vec_t;

  vec_t        tbl [8];
  int          lat, nmr, extra;
  logic [31:0] data;
  logic        flt;
  logic [11:0] maddr;
  logic [31:0] last_rdata;

  initial begin
    for (int i = 0; i < SW; i++) mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
    mem[4] = 32'h0000_0013;

    tbl[0] = '{32'h0000_0010, 0,  2 + WS, mem[4],    1'b0, 1, 12'd4};
    tbl[1] = '{32'h0000_0008, 10, 2 + WS, mem[2],    1'b0, 1, 12'd2};
    tbl[2] = '{32'h0000_4000, 0,  1,      32'h0,     1'b1, 0, 12'd0};
    tbl[3] = '{32'h0000_3FFF, 2,  2 + WS, mem[4095], 1'b0, 1, 12'd4095};
    tbl[4] = '{32'hFFFF_FFFC, 1,  1,      32'h0,     1'b1, 0, 12'd0};
    tbl[5] = '{32'h0000_0003, 0,  2 + WS, mem[0],    1'b0, 1, 12'd0};
    tbl[6] = '{32'h0000_4003, 0,  1,      32'h0,     1'b1, 0, 12'd0};
    tbl[7] = '{32'h8000_0010, 3,  1,      32'h0,     1'b1, 0, 12'd0};

    // Reset state
    repeat (3) @(negedge i_clock);
    check("rst_ready", 32'(o_bus_ready), 32'h0);
    check("rst_fault", 32'(o_bus_fault), 32'h0);
    check("rst_memrd", 32'(o_mem_read), 32'h0);
    check("rst_maddr", 32'(o_mem_address), 32'h0);
    check("rst_rdata", o_bus_rdata, 32'h0);
    i_reset_n = 1'b1;
    repeat (2) @(negedge i_clock);

    // Table vectors
    for (int k = 0; k < 8; k++) begin
      run_txn(tbl[k].addr, tbl[k].hold, 1'b0, lat, data, flt, nmr, maddr, extra);
      check($sformatf("tbl%0d_lat", k), 32'(lat), 32'(tbl[k].exp_lat));
      check($sformatf("tbl%0d_data", k), data, tbl[k].exp_data);
      check($sformatf("tbl%0d_fault", k), 32'(flt), 32'(tbl[k].exp_fault));
      check($sformatf("tbl%0d_memrd", k), 32'(nmr), 32'(tbl[k].exp_nmr));
      if (tbl[k].exp_nmr != 0)
        check($sformatf("tbl%0d_maddr", k), 32'(maddr), 32'(tbl[k].exp_maddr));
      check($sformatf("tbl%0d_extra", k), 32'(extra), 32'h0);
      check($sformatf("tbl%0d_hold", k), o_bus_rdata, tbl[k].exp_data);
    end
    last_rdata = tbl[7].exp_data;

    // Request dropped one cycle after acceptance: no ready, rdata untouched
    i_bus_address = 32'h0000_0020;
    i_bus_request = 1'b1;
    @(posedge i_clock); @(negedge i_clock);
    check("abort_memrd", 32'(o_mem_read), 32'h1);
    i_bus_request = 1'b0;
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clock); @(negedge i_clock);
      if (o_bus_ready) extra++;
    end
    $display("txn addr=00000020 aborted readies=%0d", extra);
    check("abort_noready", 32'(extra), 32'h0);
    check("abort_rdata", o_bus_rdata, last_rdata);
    run_txn(32'h0000_0024, 0, 1'b0, lat, data, flt, nmr, maddr, extra);
    check("after_abort_lat", 32'(lat), 32'(2 + WS));
    check("after_abort_data", data, mem[9]);
    check("after_abort_fault", 32'(flt), 32'h0);

`ifdef IBUS_PREFETCH_EN
    // Sequential fetch hits the prefetch buffer; a far fetch misses
    run_txn(32'h0000_0100, 0, 1'b0, lat, data, flt, nmr, maddr, extra);
    check("pf_first_lat", 32'(lat), 32'(2 + WS));
    check("pf_first_data", data, mem[64]);
    run_txn(32'h0000_0104, 0, 1'b0, lat, data, flt, nmr, maddr, extra);
    check("pf_hit_lat", 32'(lat), 32'h1);
    check("pf_hit_data", data, mem[65]);
    check("pf_hit_memrd", 32'(nmr), 32'h0);
    run_txn(32'h0000_0200, 0, 1'b0, lat, data, flt, nmr, maddr, extra);
    check("pf_miss_lat", 32'(lat), 32'(2 + WS));
    check("pf_miss_data", data, mem[128]);
    check("pf_miss_memrd", 32'(nmr), 32'h1);
`endif

    // Reset during READ: outputs clear before the next clock edge
    i_bus_address = 32'h0000_0040;
    i_bus_request = 1'b1;
    @(posedge i_clock); #1;
    check("rd_memrd", 32'(o_mem_read), 32'h1);
    check("rd_maddr", 32'(o_mem_address), 32'd16);
    #2 i_reset_n = 1'b0;
    #1;
    check("arst_memrd", 32'(o_mem_read), 32'h0);
    check("arst_maddr", 32'(o_mem_address), 32'h0);
    check("arst_rdata", o_bus_rdata, 32'h0);
    check("arst_ready", 32'(o_bus_ready), 32'h0);
    i_bus_request = 1'b0;
    @(negedge i_clock);
    i_reset_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clock); @(negedge i_clock);
      if (o_bus_ready) extra++;
    end
    check("arst_noready", 32'(extra), 32'h0);
    run_txn(32'h0000_0000, 0, 1'b0, lat, data, flt, nmr, maddr, extra);
    check("post_rst_lat", 32'(lat), 32'(2 + WS));
    check("post_rst_data", data, mem[0]);
    pf_v = 1'b0;
    model_note(32'h0000_0000);

    // Randomized fetches against the reference model
    begin
      logic [31:0] a, prev_a, exp_data;
      bit in, hit;
      int exp_lat;
      prev_a = 32'h0;
      for (int n = 0; n < 200; n++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 20) a = prev_a + 32'd4;
        else if (r < 75) a = 32'($urandom_range(0, SW - 1)) * 32'd4 + 32'($urandom_range(0, 3));
        else a = $urandom | (32'h1 << $urandom_range(14, 31));
        in = model_in_range(a);
`ifdef IBUS_PREFETCH_EN
        hit = in && pf_v && (model_word(a) == pf_w);
`else
        hit = 1'b0;
`endif
        exp_lat  = (!in || hit) ? 1 : 2 + WS;
        exp_data = in ? mem[model_word(a)] : 32'h0;
        run_txn(a, $urandom_range(0, 3), 1'b1, lat, data, flt, nmr, maddr, extra);
        check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(exp_lat));
        check($sformatf("rnd%0d_data", n), data, exp_data);
        check($sformatf("rnd%0d_fault", n), 32'(flt), 32'(!in));
        check($sformatf("rnd%0d_memrd", n), 32'(nmr), (in && !hit) ? 32'h1 : 32'h0);
        check($sformatf("rnd%0d_extra", n), 32'(extra), 32'h0);
        model_note(a);
        if (in) prev_a = a;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
